// File: rtl/sram_match_responder_pkg.sv
// Shared constants, index/width types and saturation helpers for the SRAM match responder.
// Latency: n/a (package only).
// Backpressure: n/a.
package hydra_sram_pkg;

    localparam int NUM_SRAM  = 32;    // SRAM banks
    localparam int NUM_PORTS = 16;    // write ports / matchers served
    localparam int NUM_DEST  = 16;    // destinations tracked per bank
    localparam int SRAM_CAP  = 2047;  // free_space of an empty bank
    localparam int AMT_MAX   = 511;   // packet_amount ceiling

    // Encoding of "no bank chosen" on match_best_sram.
    localparam logic [5:0] NO_SRAM = 6'd32;

    typedef logic [4:0]  sram_idx_t;
    typedef logic [5:0]  sram_sel_t;
    typedef logic [3:0]  dest_t;
    typedef logic [10:0] free_t;
    typedef logic [10:0] len_t;
    typedef logic [8:0]  amt_t;

    // Clamp v into [0, hi].
    function automatic int clamp_range(input int v, input int hi);
        if (v < 0) begin
            return 0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

    // True when v lies outside [0, hi].
    function automatic logic out_of_range(input int v, input int hi);
        return (v < 0) || (v > hi);
    endfunction

endpackage

// File: rtl/sram_match_responder_lock_table.sv
// Per-bank write-lock ownership: resolves matcher claims, issues grant/reject pulses, applies releases.
// Latency: grant/reject and the new owner are visible one cycle after match_suc / lock_release.
// Backpressure: none; every claim is answered with exactly one grant or reject pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   match_suc           per-port claim pulse
//   match_best_sram     per-port claimed bank (6b; 32 and above means none)
//   lock_release        per-port request to drop the lock it holds
//   owner_vld/owner_id  current owner of each bank (registered)
//   lock_grant/reject   one-cycle answer to each claim (registered)
module sram_lock_table
    import hydra_sram_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           match_suc,
    input  logic [NUM_PORTS*6-1:0]         match_best_sram,
    input  logic [NUM_PORTS-1:0]           lock_release,
    output logic [NUM_SRAM-1:0]            owner_vld,
    output logic [NUM_SRAM*$clog2(NUM_PORTS)-1:0] owner_id,
    output logic [NUM_PORTS-1:0]           lock_grant,
    output logic [NUM_PORTS-1:0]           lock_reject
);

    localparam int PW = $clog2(NUM_PORTS);

    sram_sel_t [NUM_PORTS-1:0] best;
    sram_idx_t [NUM_PORTS-1:0] best_idx;

    logic [NUM_SRAM-1:0]          owner_vld_q, owner_vld_d;
    logic [NUM_SRAM-1:0][PW-1:0]  owner_id_q,  owner_id_d;
    logic [NUM_PORTS-1:0]         lock_grant_q, lock_grant_d;
    logic [NUM_PORTS-1:0]         lock_reject_q, lock_reject_d;

    // Ownership as seen by this cycle's claims: releases land before claims.
    logic [NUM_SRAM-1:0]          vld_eff;
    // A lower-indexed port claims the same bank this cycle.
    logic [NUM_PORTS-1:0]         lower_claim;

    assign best = match_best_sram;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            best_idx[i] = best[i][4:0];
        end
    end

    always_comb begin
        vld_eff = owner_vld_q;
        for (int b = 0; b < NUM_SRAM; b++) begin
            if (owner_vld_q[b] && lock_release[owner_id_q[b]]) begin
                vld_eff[b] = 1'b0;
            end
        end
    end

    always_comb begin
        lower_claim = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if ((j < i) && match_suc[j] && (best[j] == best[i])) begin
                    lower_claim[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        lock_grant_d  = '0;
        lock_reject_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (match_suc[i]) begin
                if (best[i] >= NO_SRAM) begin
                    lock_reject_d[i] = 1'b1;
                end else if (vld_eff[best_idx[i]]) begin
                    // Re-claiming a bank this port already holds is a grant.
                    if (owner_id_q[best_idx[i]] == PW'(i)) begin
                        lock_grant_d[i] = 1'b1;
                    end else begin
                        lock_reject_d[i] = 1'b1;
                    end
                end else if (lower_claim[i]) begin
                    lock_reject_d[i] = 1'b1;
                end else begin
                    lock_grant_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        owner_vld_d = vld_eff;
        owner_id_d  = owner_id_q;
        // A port holds one lock: a fresh grant drops whatever else it owned.
        for (int b = 0; b < NUM_SRAM; b++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (lock_grant_d[i] && vld_eff[b] && (owner_id_q[b] == PW'(i)) &&
                    (best_idx[i] != sram_idx_t'(b))) begin
                    owner_vld_d[b] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (lock_grant_d[i]) begin
                owner_vld_d[best_idx[i]] = 1'b1;
                owner_id_d[best_idx[i]]  = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_vld_q   <= '0;
            owner_id_q    <= '0;
            lock_grant_q  <= '0;
            lock_reject_q <= '0;
        end else begin
            owner_vld_q   <= owner_vld_d;
            owner_id_q    <= owner_id_d;
            lock_grant_q  <= lock_grant_d;
            lock_reject_q <= lock_reject_d;
        end
    end

    assign owner_vld   = owner_vld_q;
    assign owner_id    = owner_id_q;
    assign lock_grant  = lock_grant_q;
    assign lock_reject = lock_reject_q;

endmodule

// File: rtl/sram_match_responder.sv
// Back-end responder for the write-side SRAM matchers: scans banks per port, reports status, grants locks, tracks occupancy.
// Latency: bank index and its status are registered together, one cycle from table state to outputs.
// Backpressure: none; outputs refresh every cycle, wr/rd events are absorbed every cycle.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   match_enable                per-port scan request (status is driven regardless)
//   new_dest                    per-port destination used to pick packet_amount
//   match_suc/match_best_sram   per-port lock claim and claimed bank
//   lock_release                per-port drop of the held lock
//   match_sram                  per-port bank presented this cycle
//   accessible                  presented bank is unowned or owned by this port
//   free_space/packet_amount    presented bank's free units / packets for new_dest
//   lock_grant/lock_reject      one-cycle answer to a claim
//   wr_*/rd_*                   enqueue/dequeue occupancy events
//   err_ovf                     sticky: an occupancy counter saturated
module sram_match_responder
    import hydra_sram_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      match_enable,
    input  logic [NUM_PORTS*4-1:0]    new_dest,
    input  logic [NUM_PORTS-1:0]      match_suc,
    input  logic [NUM_PORTS*6-1:0]    match_best_sram,
    output logic [NUM_PORTS*5-1:0]    match_sram,
    output logic [NUM_PORTS-1:0]      accessible,
    output logic [NUM_PORTS*11-1:0]   free_space,
    output logic [NUM_PORTS*9-1:0]    packet_amount,
    output logic [NUM_PORTS-1:0]      lock_grant,
    output logic [NUM_PORTS-1:0]      lock_reject,
    input  logic [NUM_PORTS-1:0]      lock_release,
    input  logic                      wr_valid,
    input  logic [4:0]                wr_sram,
    input  logic [3:0]                wr_dest,
    input  logic [10:0]               wr_len,
    input  logic                      rd_valid,
    input  logic [4:0]                rd_sram,
    input  logic [3:0]                rd_dest,
    input  logic [10:0]               rd_len,
    output logic                      err_ovf
);

    localparam int PW = $clog2(NUM_PORTS);

    // Status is presented every cycle whether or not a port is scanning.
    logic unused_match_enable;
    assign unused_match_enable = ^match_enable;

    dest_t [NUM_PORTS-1:0] dest;
    assign dest = new_dest;

    sram_idx_t                          scan_ptr_q, scan_ptr_d;
    free_t [NUM_SRAM-1:0]               free_q, free_d;
    amt_t  [NUM_SRAM-1:0][NUM_DEST-1:0] amt_q,  amt_d;
    logic                               err_ovf_q, err_ovf_d;

    sram_idx_t [NUM_PORTS-1:0]          pres_bank;
    sram_idx_t [NUM_PORTS-1:0]          match_sram_q,    match_sram_d;
    free_t     [NUM_PORTS-1:0]          free_space_q,    free_space_d;
    amt_t      [NUM_PORTS-1:0]          packet_amount_q, packet_amount_d;
    logic      [NUM_PORTS-1:0]          accessible_q,    accessible_d;

    logic [NUM_SRAM-1:0]                owner_vld;
    logic [NUM_SRAM*PW-1:0]             owner_id_flat;
    logic [NUM_SRAM-1:0][PW-1:0]        owner_id;

    assign owner_id = owner_id_flat;

    sram_lock_table u_lock_table (
        .clk             (clk),
        .rst             (rst),
        .match_suc       (match_suc),
        .match_best_sram (match_best_sram),
        .lock_release    (lock_release),
        .owner_vld       (owner_vld),
        .owner_id        (owner_id_flat),
        .lock_grant      (lock_grant),
        .lock_reject     (lock_reject)
    );

    // Port i trails the shared pointer by an even stride so no two ports
    // look at the same bank in the same cycle.
    always_comb begin
        scan_ptr_d = scan_ptr_q + 5'd1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pres_bank[i]       = scan_ptr_q + sram_idx_t'(2 * i);
            match_sram_d[i]    = pres_bank[i];
            free_space_d[i]    = free_q[pres_bank[i]];
            packet_amount_d[i] = amt_q[pres_bank[i]][dest[i]];
            accessible_d[i]    = !owner_vld[pres_bank[i]] ||
                                 (owner_id[pres_bank[i]] == PW'(i));
        end
    end

    // Occupancy update: wr and rd on the same bank fold into one net change,
    // so the intermediate value never saturates on its own.
    always_comb begin
        int   nf;
        int   na;
        logic ovf;
        nf        = 0;
        na        = 0;
        ovf       = 1'b0;
        free_d    = free_q;
        amt_d     = amt_q;
        for (int b = 0; b < NUM_SRAM; b++) begin
            nf = int'(free_q[b]);
            if (wr_valid && (wr_sram == sram_idx_t'(b))) begin
                nf = nf - int'(wr_len);
            end
            if (rd_valid && (rd_sram == sram_idx_t'(b))) begin
                nf = nf + int'(rd_len);
            end
            ovf       = ovf | out_of_range(nf, SRAM_CAP);
            free_d[b] = free_t'(clamp_range(nf, SRAM_CAP));
            for (int d = 0; d < NUM_DEST; d++) begin
                na = int'(amt_q[b][d]);
                if (wr_valid && (wr_sram == sram_idx_t'(b)) && (wr_dest == dest_t'(d))) begin
                    na = na + 1;
                end
                if (rd_valid && (rd_sram == sram_idx_t'(b)) && (rd_dest == dest_t'(d))) begin
                    na = na - 1;
                end
                ovf         = ovf | out_of_range(na, AMT_MAX);
                amt_d[b][d] = amt_t'(clamp_range(na, AMT_MAX));
            end
        end
        err_ovf_d = err_ovf_q | ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ptr_q      <= '0;
            free_q          <= {NUM_SRAM{free_t'(SRAM_CAP)}};
            amt_q           <= '0;
            err_ovf_q       <= 1'b0;
            match_sram_q    <= '0;
            free_space_q    <= '0;
            packet_amount_q <= '0;
            accessible_q    <= '0;
        end else begin
            scan_ptr_q      <= scan_ptr_d;
            free_q          <= free_d;
            amt_q           <= amt_d;
            err_ovf_q       <= err_ovf_d;
            match_sram_q    <= match_sram_d;
            free_space_q    <= free_space_d;
            packet_amount_q <= packet_amount_d;
            accessible_q    <= accessible_d;
        end
    end

    assign match_sram    = match_sram_q;
    assign free_space    = free_space_q;
    assign packet_amount = packet_amount_q;
    assign accessible    = accessible_q;
    assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_sram_match_responder.sv
// Randomized and directed bench for sram_match_responder against a bank/owner reference model.
// Latency: expectations are formed before each edge and compared 1 time unit after it.
// Backpressure: n/a.
module tb_sram_match_responder;

    localparam int P   = 16;
    localparam int NS  = 32;
    localparam int CAP = 2047;
    localparam int AMX = 511;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [P-1:0]    match_enable, match_suc, lock_release;
    logic [P*4-1:0]  new_dest;
    logic [P*6-1:0]  match_best_sram;
    logic [P*5-1:0]  match_sram;
    logic [P-1:0]    accessible, lock_grant, lock_reject;
    logic [P*11-1:0] free_space;
    logic [P*9-1:0]  packet_amount;
    logic            wr_valid, rd_valid, err_ovf;
    logic [4:0]      wr_sram, rd_sram;
    logic [3:0]      wr_dest, rd_dest;
    logic [10:0]     wr_len, rd_len;

    sram_match_responder dut (
        .clk(clk), .rst(rst),
        .match_enable(match_enable), .new_dest(new_dest),
        .match_suc(match_suc), .match_best_sram(match_best_sram),
        .match_sram(match_sram), .accessible(accessible),
        .free_space(free_space), .packet_amount(packet_amount),
        .lock_grant(lock_grant), .lock_reject(lock_reject),
        .lock_release(lock_release),
        .wr_valid(wr_valid), .wr_sram(wr_sram), .wr_dest(wr_dest), .wr_len(wr_len),
        .rd_valid(rd_valid), .rd_sram(rd_sram), .rd_dest(rd_dest), .rd_len(rd_len),
        .err_ovf(err_ovf)
    );

    // Reference state: what each bank holds and who owns it.
    int m_free [NS];
    int m_amt  [NS][16];
    int m_owner[NS];   // -1 = nobody
    int m_ptr;
    bit m_err;

    logic [P*5-1:0]  e_sram;
    logic [P*11-1:0] e_free;
    logic [P*9-1:0]  e_amt;
    logic [P-1:0]    e_acc, e_grant, e_rej;
    logic            e_err;

    int n_vec = 0;
    int n_err = 0;
    bit hit;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NS; b++) begin
            m_free[b]  = CAP;
            m_owner[b] = -1;
            for (int d = 0; d < 16; d++) m_amt[b][d] = 0;
        end
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        match_enable    = '0;
        match_suc       = '0;
        lock_release    = '0;
        match_best_sram = '0;
        wr_valid = 1'b0; wr_sram = '0; wr_dest = '0; wr_len = '0;
        rd_valid = 1'b0; rd_sram = '0; rd_dest = '0; rd_len = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sram"},  match_sram,    0);
        chk({tag, "_free"},  free_space,    0);
        chk({tag, "_amt"},   packet_amount, 0);
        chk({tag, "_acc"},   accessible,    0);
        chk({tag, "_grant"}, lock_grant,    0);
        chk({tag, "_rej"},   lock_reject,   0);
        chk({tag, "_err"},   err_ovf,       0);
    endtask

    // Predict the outputs of the coming edge from the current inputs, advance
    // the model, clock once and compare.
    task automatic cycle();
        int  pre[NS];
        bit  taken[NS];
        int  bank, d, best, nf, na;
        for (int i = 0; i < P; i++) begin
            bank = (m_ptr + 2 * i) % NS;
            d    = int'(new_dest[i*4 +: 4]);
            e_sram[i*5 +: 5]  = 5'(bank);
            e_free[i*11 +: 11] = 11'(m_free[bank]);
            e_amt[i*9 +: 9]   = 9'(m_amt[bank][d]);
            e_acc[i]          = (m_owner[bank] < 0) || (m_owner[bank] == i);
        end
        // Releases happen first, then claims in ascending port order.
        for (int b = 0; b < NS; b++) begin
            pre[b] = m_owner[b];
            if (pre[b] >= 0 && lock_release[pre[b]]) pre[b] = -1;
            m_owner[b] = pre[b];
            taken[b]   = 1'b0;
        end
        e_grant = '0;
        e_rej   = '0;
        for (int i = 0; i < P; i++) begin
            if (match_suc[i]) begin
                best = int'(match_best_sram[i*6 +: 6]);
                if (best >= NS || !(pre[best] == i || (pre[best] < 0 && !taken[best]))) begin
                    e_rej[i] = 1'b1;
                end else begin
                    e_grant[i]  = 1'b1;
                    taken[best] = 1'b1;
                    for (int b = 0; b < NS; b++) if (m_owner[b] == i) m_owner[b] = -1;
                    m_owner[best] = i;
                end
            end
        end
        for (int b = 0; b < NS; b++) begin
            nf = m_free[b];
            if (wr_valid && int'(wr_sram) == b) nf = nf - int'(wr_len);
            if (rd_valid && int'(rd_sram) == b) nf = nf + int'(rd_len);
            if (nf < 0)   begin nf = 0;   m_err = 1'b1; end
            if (nf > CAP) begin nf = CAP; m_err = 1'b1; end
            m_free[b] = nf;
            for (int dd = 0; dd < 16; dd++) begin
                na = m_amt[b][dd];
                if (wr_valid && int'(wr_sram) == b && int'(wr_dest) == dd) na = na + 1;
                if (rd_valid && int'(rd_sram) == b && int'(rd_dest) == dd) na = na - 1;
                if (na < 0)   begin na = 0;   m_err = 1'b1; end
                if (na > AMX) begin na = AMX; m_err = 1'b1; end
                m_amt[b][dd] = na;
            end
        end
        e_err = m_err;
        m_ptr = (m_ptr + 1) % NS;
        @(posedge clk);
        #1;
        chk("match_sram",    match_sram,    e_sram);
        chk("free_space",    free_space,    e_free);
        chk("packet_amount", packet_amount, e_amt);
        chk("accessible",    accessible,    e_acc);
        chk("lock_grant",    lock_grant,    e_grant);
        chk("lock_reject",   lock_reject,   e_rej);
        chk("err_ovf",       err_ovf,       e_err);
    endtask

    // Run idle cycles until the given port presents the given bank (bounded).
    task automatic await_bank(input int port, input int bank, output bit found);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle();
            if (match_sram[port*5 +: 5] == 5'(bank)) found = 1'b1;
        end
        chk("await_bank", found, 1);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        new_dest = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // 1: idle scan, wrap and port stride.
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (k == 1) begin
                chk("t1_p0_first", match_sram[4:0], 0);
                chk("t1_p3_first", match_sram[19:15], 6);
                chk("t1_free",     free_space[10:0], CAP);
                chk("t1_acc",      accessible, 16'hffff);
            end
            if (k == 32) chk("t1_p0_last", match_sram[4:0], 31);
            if (k == 33) chk("t1_p0_wrap", match_sram[4:0], 0);
        end

        // 2: three enqueues to (5,2,len10).
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1; wr_sram = 5'd5; wr_dest = 4'd2; wr_len = 11'd10;
            cycle();
        end
        idle_inputs();
        new_dest[3:0] = 4'd2;
        await_bank(0, 5, hit);
        chk("t2_free", free_space[10:0], 2017);
        chk("t2_amt",  packet_amount[8:0], 3);

        // 3: ports 1 and 4 claim bank 7 together.
        match_suc[1] = 1'b1; match_best_sram[1*6 +: 6] = 6'd7;
        match_suc[4] = 1'b1; match_best_sram[4*6 +: 6] = 6'd7;
        cycle();
        idle_inputs();
        chk("t3_grant1", lock_grant[1], 1);
        chk("t3_rej4",   lock_reject[4], 1);
        chk("t3_grant4", lock_grant[4], 0);
        await_bank(4, 7, hit);
        chk("t3_acc4", accessible[4], 0);
        await_bank(1, 7, hit);
        chk("t3_acc1", accessible[1], 1);

        // 4: release and a new claim in one cycle.
        lock_release[1] = 1'b1;
        match_suc[1] = 1'b1; match_best_sram[1*6 +: 6] = 6'd9;
        cycle();
        idle_inputs();
        chk("t4_grant1", lock_grant[1], 1);
        chk("t4_rej1",   lock_reject[1], 0);
        await_bank(4, 7, hit);
        chk("t4_acc4_b7", accessible[4], 1);
        await_bank(4, 9, hit);
        chk("t4_acc4_b9", accessible[4], 0);

        // 5: wr and rd cancel; rd on an empty bank saturates; amount ceiling.
        wr_valid = 1'b1; wr_sram = 5'd3; wr_dest = 4'd1; wr_len = 11'd8;
        rd_valid = 1'b1; rd_sram = 5'd3; rd_dest = 4'd1; rd_len = 11'd8;
        cycle();
        idle_inputs();
        new_dest[3:0] = 4'd1;
        await_bank(0, 3, hit);
        chk("t5_free", free_space[10:0], CAP);
        chk("t5_amt",  packet_amount[8:0], 0);
        chk("t5_err0", err_ovf, 0);
        rd_valid = 1'b1; rd_sram = 5'd10; rd_dest = 4'd0; rd_len = 11'd5;
        cycle();
        idle_inputs();
        chk("t5_err1", err_ovf, 1);
        new_dest[3:0] = 4'd0;
        await_bank(0, 10, hit);
        chk("t5_empty_amt",  packet_amount[8:0], 0);
        chk("t5_empty_free", free_space[10:0], CAP);
        for (int k = 0; k < 515; k++) begin
            wr_valid = 1'b1; wr_sram = 5'd20; wr_dest = 4'd5; wr_len = 11'd0;
            cycle();
        end
        idle_inputs();
        new_dest[3:0] = 4'd5;
        await_bank(0, 20, hit);
        chk("t5_amt_max", packet_amount[8:0], AMX);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            match_enable = 16'($urandom());
            new_dest     = {$urandom(), $urandom()};
            for (int i = 0; i < P; i++) begin
                match_suc[i]    = ($urandom_range(7) == 0);
                lock_release[i] = ($urandom_range(15) == 0);
                match_best_sram[i*6 +: 6] = 6'($urandom_range(33));
            end
            wr_valid = ($urandom_range(9) < 7);
            wr_sram  = 5'($urandom_range(31));
            wr_dest  = 4'($urandom_range(15));
            wr_len   = 11'($urandom_range(300));
            rd_valid = ($urandom_range(9) < 3);
            rd_sram  = ($urandom_range(3) == 0) ? wr_sram : 5'($urandom_range(31));
            rd_dest  = ($urandom_range(3) == 0) ? wr_dest : 4'($urandom_range(15));
            rd_len   = 11'($urandom_range(300));
            cycle();
        end
        idle_inputs();

        // 6: reset while a lock is held.
        lock_release = '1;
        cycle();
        idle_inputs();
        match_suc[2] = 1'b1; match_best_sram[2*6 +: 6] = 6'd12;
        cycle();
        idle_inputs();
        chk("t6_grant2", lock_grant[2], 1);
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async");
        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("t6_held");
        rst = 1'b0;
        new_dest = '0;
        await_bank(2, 12, hit);
        chk("t6_acc2",  accessible[2], 1);
        chk("t6_free2", free_space[2*11 +: 11], CAP);
        chk("t6_err",   err_ovf, 0);
        await_bank(0, 20, hit);
        chk("t6_amt_cleared", packet_amount[8:0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
